// File: rtl/seq_divider8_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the iteration counter sizing rule.
package seq_divider8_pkg;

  localparam int DIV_WIDTH = 8;

  // The counter must hold values up to WIDTH, hence the +1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider8_add_sub_ripple.sv
// Parameterised ripple adder/subtractor: op=1 inverts b and injects a carry,
// so cout=1 on subtraction means "no borrow" (a >= b).
module add_sub_ripple #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] w_b;

  assign w_b = b ^ {WIDTH{op}};

  always_comb begin
    logic c;
    // NOTE: combinational blocks use blocking '=' so the carry ripples within
    // one evaluation, and every output is assigned on every pass (no latches).
    c   = op;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ w_b[i] ^ c;
      c      = (a[i] & w_b[i]) | (c & (a[i] ^ w_b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_divider8.sv
// Sequential unsigned restoring divider: one shift-subtract step per clock,
// valid/ready handshakes on both the operand and result sides.
module seq_divider8
  import seq_divider8_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_count;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_no_borrow;
  logic             w_unused_rem_msb;

  assign w_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};

  add_sub_ripple #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .a    (w_shift),
    .b    ({1'b0, r_dvs}),
    .op   (1'b1),
    .sum  (w_diff),
    .cout (w_no_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quo   <= '0;
      r_count <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_dbz   <= (divisor == '0);
            r_rem   <= '0;
            r_quo   <= '0;
            r_count <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem   <= w_no_borrow ? w_diff : w_shift;
          r_quo   <= {r_quo[WIDTH-2:0], w_no_borrow};
          r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode state only: no combinational input-to-output path.
  assign in_ready         = (r_state == IDLE);
  assign out_valid        = (r_state == DONE);
  assign quotient         = r_quo;
  assign remainder        = r_rem[WIDTH-1:0];
  assign div_by_zero      = r_dbz;
  assign w_unused_rem_msb = r_rem[WIDTH];

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: directed vector table, handshake and
// reset corner sequences, and random operands against an arithmetic model.
module tb_seq_divider8;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  seq_divider8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Division by zero yields all-ones quotient and the dividend as remainder.
  function automatic vec_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    vec_t v;
    v.dvd = dvd;
    v.dvs = dvs;
    v.dbz = (dvs == 0);
    if (dvs == 0) begin
      v.q = '1;
      v.r = dvd;
    end else begin
      v.q = dvd / dvs;
      v.r = dvd % dvs;
    end
    return v;
  endfunction

  task automatic start_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, output int acc_cyc);
    int t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic finish_op(input string tag, input vec_t e);
    int k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd8);
    check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
    check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_after"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    vec_t vecs[9];
    vec_t e;
    int   acc;
    int   prev_acc;
    int   k;
    bit   saw_ready;
    bit   saw_valid;
    bit   stable;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[3] = '{8'd77,  8'd0,   8'hFF,  8'd77,  1'b1};
    vecs[4] = '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0};
    vecs[5] = '{8'd9,   8'd2,   8'd4,   8'd1,   1'b0};
    vecs[6] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
    vecs[7] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[8] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #22;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_outputs", {15'd0, div_by_zero, remainder, quotient}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors back to back; spacing between accepts must be >= 10.
    prev_acc = 0;
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].dvd, vecs[i].dvs, acc);
      if (i > 0) check($sformatf("vec%0d_spacing", i), 32'(acc - prev_acc >= 10), 32'd1);
      prev_acc = acc;
      finish_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result held for 5 cycles while out_ready stays low.
    start_op(8'd200, 8'd13, acc);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("bp_latency", 32'(k), 32'd8);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (quotient !== 8'd15 || remainder !== 8'd5 || in_ready !== 1'b0 || out_valid !== 1'b1)
        stable = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    check("bp_hold", 32'(stable), 32'd1);
    check("bp_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);

    // Asynchronous reset during iteration 4 discards the operation.
    start_op(8'd90, 8'd4, acc);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_flags", {30'd0, out_valid, in_ready}, 32'b01);
    check("rst_mid_outputs", {15'd0, div_by_zero, remainder, quotient}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("rst_no_result", 32'(saw_valid), 32'd0);
    start_op(8'd9, 8'd2, acc);
    finish_op("after_rst", model(8'd9, 8'd2));

    // Operand noise during RUN must not disturb the accepted operands.
    start_op(8'd123, 8'd10, acc);
    k = 0;
    saw_ready = 1'b0;
    while (!out_valid && k < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      k++;
      if (in_ready) saw_ready = 1'b1;
    end
    check("noise_latency", 32'(k), 32'd8);
    check("noise_in_ready_low", 32'(saw_ready), 32'd0);
    e = model(8'd123, 8'd10);
    check("noise_quotient", 32'(quotient), 32'(e.q));
    check("noise_remainder", 32'(remainder), 32'(e.r));

    // in_valid and out_ready together in DONE: the new operand waits for IDLE.
    in_valid  = 1'b1;
    dividend  = 8'd50;
    divisor   = 8'd6;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("overlap_idle", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("overlap_accepted", 32'(in_ready), 32'd0);
    finish_op("overlap", model(8'd50, 8'd6));

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      start_op(a, b, acc);
      finish_op($sformatf("rand%0d_%0d_%0d", i, a, b), model(a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
